fifo_memory_flex: RTL and testbench
===================================

Name: fifo_memory_flex

Overview:
Parametrised synchronous single-clock FIFO; next generation of fifo_memory. Adds fill count, programmable almost-full/almost-empty flags, selectable read mode (registered or first-word-fall-through) and a read_valid qualifier. Sits between any producer/consumer pair in one clock domain.

Parameters:
DATA_WIDTH, 8, width of each entry in bits
ADDR_WIDTH, 5, pointer width; DEPTH = 2**ADDR_WIDTH entries, all usable
ALMOST_FULL_THRESH, 28, almost_full asserted when count >= this value; legal range 1..DEPTH-1
ALMOST_EMPTY_THRESH, 4, almost_empty asserted when count <= this value; legal range 1..DEPTH-1
FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
write_enable  input  1  write request
write_data  input  DATA_WIDTH  write data
read_enable  input  1  read request
read_data  output  DATA_WIDTH  read data
read_valid  output  1  read_data qualifier
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= ALMOST_FULL_THRESH
almost_empty  output  1  count <= ALMOST_EMPTY_THRESH
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst=1 at edge): wr_ptr, rd_ptr, count <= 0; empty=1, full=0, almost_empty=1, almost_full=0, read_data=0, read_valid=0. Memory array not reset. Requests in the reset cycle are ignored. Reset mid-operation discards all contents.
- Write accepted iff write_enable && !full. Data stored at mem[wr_ptr]; wr_ptr increments, wrapping naturally at DEPTH.
- Read accepted iff read_enable && !empty. rd_ptr increments, wrapping naturally.
- A write when full is rejected even if a read is accepted in the same cycle. A read when empty is rejected even if a write is accepted in the same cycle.
- count: +1 on write only, -1 on read only, unchanged on both or neither.
- All flags are registered and derived from the next count; they change on the same edge as the accepting transaction.
- FWFT=0: on an accepted read, read_data <= mem[rd_ptr] at that edge, so it is valid the cycle after the request; read_valid pulses high for that one cycle. read_data holds its last value otherwise, including after a rejected read.
- FWFT=1: read_data = mem[rd_ptr] (combinational from the registered pointer). read_valid = !empty. A write into an empty FIFO is visible the cycle after the write edge. read_enable acts as an acknowledge/pop of the word currently shown.
- Elaboration-time error if either threshold is outside 1..DEPTH-1.

Optional Feature:
Macro: FIFO_MEMORY_ERR_FLAGS_EN
- Defined: adds input err_clear (1 bit) and outputs overflow and underflow (1 bit each), both sticky and reset to 0.
  - overflow sets on write_enable && full.
  - underflow sets on read_enable && empty.
  - err_clear clears both synchronously; if a set and a clear occur in the same cycle, the set wins.
- Undefined: the three ports and their logic are absent. Rejected requests are silently dropped.

Test Plan:
(DATA_WIDTH=8, ADDR_WIDTH=5, thresholds 28/4, FWFT=0 unless stated.)
1. Fill: after reset, write 0x00..0x1F back-to-back -> almost_empty drops when count=5; almost_full rises when count=28; full=1 and count=32 after the 32nd edge. A 33rd write is rejected: count stays 32, overflow=1 (macro on).
2. Drain: issue 32 back-to-back reads -> read_data is 0x00..0x1F, each one cycle after its read, with read_valid high each cycle; empty=1 after the 32nd read. A 33rd read leaves read_data=0x1F, read_valid=0, and sets underflow=1.
3. Wrap-around: write 20, read 20, write 20 (0x40..0x53), read 20 -> exact order 0x40..0x53 across the pointer wrap at 32; count returns to 0.
4. Simultaneous: at count=16, read+write for 10 cycles -> count stays 16. At full, read+write -> write rejected, count=31. At empty, read+write -> read rejected, count=1.
5. FWFT=1: write 0xA5 into empty -> next cycle empty=0, read_valid=1, read_data=0xA5 with no read issued. Then read_enable for one cycle -> empty=1 on the following cycle.
6. Reset mid-operation: at count=10, assert rst with write_enable=1 -> next cycle count=0, empty=1, almost_empty=1, overflow/underflow=0. Then write 0x3C and read it -> 0x3C returned.

Source files
------------

// File: rtl/fifo_memory_flex.sv
// Single-clock FIFO with fill count, almost-full/almost-empty flags and a registered or FWFT read port.
// Optional sticky overflow/underflow flags with err_clear are enabled by defining FIFO_MEMORY_ERR_FLAGS_EN.
module fifo_memory_flex #(
    parameter int DATA_WIDTH          = 8,
    parameter int ADDR_WIDTH          = 5,
    parameter int ALMOST_FULL_THRESH  = 28,
    parameter int ALMOST_EMPTY_THRESH = 4,
    parameter int FWFT                = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
`ifdef FIFO_MEMORY_ERR_FLAGS_EN
    input  logic                  err_clear,
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic [ADDR_WIDTH:0]   count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(ALMOST_FULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(ALMOST_EMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE_C = ADDR_WIDTH'(1);

    if (ALMOST_FULL_THRESH < 1 || ALMOST_FULL_THRESH > DEPTH - 1) begin : g_af_thresh_bad
        $error("ALMOST_FULL_THRESH must lie in 1..DEPTH-1");
    end
    if (ALMOST_EMPTY_THRESH < 1 || ALMOST_EMPTY_THRESH > DEPTH - 1) begin : g_ae_thresh_bad
        $error("ALMOST_EMPTY_THRESH must lie in 1..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, empty_q, almost_full_q, almost_empty_q;
    logic                  do_write, do_read;

    // Handshake: a write is taken on any edge where write_enable is high and the FIFO is
    // not full; a read is taken where read_enable is high and it is not empty. Requests that
    // fail their own check are dropped regardless of what the other side does that cycle.
    assign do_write = write_enable && !full_q  && !rst;
    assign do_read  = read_enable  && !empty_q && !rst;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_write) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE_C;
        end
        if (do_read) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE_C;
        end
        case ({do_write, do_read})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
    end

    // Flags are computed from the next count so they move on the accepting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            full_q         <= (count_d == DEPTH_C);
            empty_q        <= (count_d == '0);
            almost_full_q  <= (count_d >= AF_C);
            almost_empty_q <= (count_d <= AE_C);
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= write_data;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is shown directly; masked to zero while empty so stale memory never leaks.
        assign read_data  = empty_q ? '0 : mem_q[rd_ptr_q];
        assign read_valid = !empty_q;
    end else begin : g_registered
        logic [DATA_WIDTH-1:0] read_data_q;
        logic                  read_valid_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                read_data_q  <= '0;
                read_valid_q <= 1'b0;
            end else begin
                read_valid_q <= do_read;
                if (do_read) begin
                    read_data_q <= mem_q[rd_ptr_q];
                end
            end
        end

        assign read_data  = read_data_q;
        assign read_valid = read_valid_q;
    end

`ifdef FIFO_MEMORY_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    // A set in the same cycle as err_clear wins, so no event is ever lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (write_enable && full_q) begin
                overflow_q <= 1'b1;
            end else if (err_clear) begin
                overflow_q <= 1'b0;
            end
            if (read_enable && empty_q) begin
                underflow_q <= 1'b1;
            end else if (err_clear) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign count        = count_q;

endmodule

// File: tb/tb_fifo_memory_flex.sv
// Bench for fifo_memory_flex: a registered-read and an FWFT instance share one stimulus stream
// and are compared every cycle against a queue model, plus directed literal expectations.
module tb_fifo_memory_flex;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int AF_T  = 28;
    localparam int AE_T  = 4;

    logic          clk;
    logic          rst;
    logic          write_enable;
    logic [DW-1:0] write_data;
    logic          read_enable;
    logic          err_clear;

    logic [DW-1:0] rd0, rd1;
    logic          rv0, rv1, full0, full1, empty0, empty1;
    logic          af0, af1, ae0, ae1;
    logic [AW:0]   count0, count1;
`ifdef FIFO_MEMORY_ERR_FLAGS_EN
    logic          ovf0, ovf1, unf0, unf1;
`endif

    int checks   = 0;
    int failures = 0;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    fifo_memory_flex #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .ALMOST_FULL_THRESH(AF_T), .ALMOST_EMPTY_THRESH(AE_T), .FWFT(0)
    ) dut0 (
        .clk(clk), .rst(rst),
        .write_enable(write_enable), .write_data(write_data),
        .read_enable(read_enable),
        .read_data(rd0), .read_valid(rv0),
        .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0),
`ifdef FIFO_MEMORY_ERR_FLAGS_EN
        .err_clear(err_clear), .overflow(ovf0), .underflow(unf0),
`endif
        .count(count0)
    );

    fifo_memory_flex #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .ALMOST_FULL_THRESH(AF_T), .ALMOST_EMPTY_THRESH(AE_T), .FWFT(1)
    ) dut1 (
        .clk(clk), .rst(rst),
        .write_enable(write_enable), .write_data(write_data),
        .read_enable(read_enable),
        .read_data(rd1), .read_valid(rv1),
        .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1),
`ifdef FIFO_MEMORY_ERR_FLAGS_EN
        .err_clear(err_clear), .overflow(ovf1), .underflow(unf1),
`endif
        .count(count1)
    );

    // ---------------- scoreboard / model ----------------
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_rd;
    logic          exp_rv;
    logic          exp_ovf, exp_unf;
    logic          model_ok = 1'b0;
    logic          m_wacc, m_racc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            exp_q.delete();
            exp_rd   = '0;
            exp_rv   = 1'b0;
            exp_ovf  = 1'b0;
            exp_unf  = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (write_enable && exp_q.size() == DEPTH) exp_ovf = 1'b1;
            else if (err_clear) exp_ovf = 1'b0;
            if (read_enable && exp_q.size() == 0) exp_unf = 1'b1;
            else if (err_clear) exp_unf = 1'b0;
            m_wacc = write_enable && (exp_q.size() < DEPTH);
            m_racc = read_enable && (exp_q.size() > 0);
            exp_rv = m_racc;
            if (m_racc) exp_rd = exp_q.pop_front();
            if (m_wacc) exp_q.push_back(write_data);
        end
    end

    always @(posedge clk) begin
        #1;
        if (model_ok) begin
            check("count0", 32'(count0), 32'(exp_q.size()));
            check("count1", 32'(count1), 32'(exp_q.size()));
            check("full0",  32'(full0),  32'(exp_q.size() == DEPTH));
            check("full1",  32'(full1),  32'(exp_q.size() == DEPTH));
            check("empty0", 32'(empty0), 32'(exp_q.size() == 0));
            check("empty1", 32'(empty1), 32'(exp_q.size() == 0));
            check("af0",    32'(af0),    32'(exp_q.size() >= AF_T));
            check("af1",    32'(af1),    32'(exp_q.size() >= AF_T));
            check("ae0",    32'(ae0),    32'(exp_q.size() <= AE_T));
            check("ae1",    32'(ae1),    32'(exp_q.size() <= AE_T));
            check("rv0",    32'(rv0),    32'(exp_rv));
            check("rd0",    32'(rd0),    32'(exp_rd));
            check("rv1",    32'(rv1),    32'(exp_q.size() > 0));
            if (exp_q.size() > 0) check("rd1", 32'(rd1), 32'(exp_q[0]));
`ifdef FIFO_MEMORY_ERR_FLAGS_EN
            check("ovf0", 32'(ovf0), 32'(exp_ovf));
            check("unf0", 32'(unf0), 32'(exp_unf));
            check("ovf1", 32'(ovf1), 32'(exp_ovf));
            check("unf1", 32'(unf1), 32'(exp_unf));
`endif
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic we, input logic [DW-1:0] wd, input logic re);
        write_enable = we;
        write_data   = wd;
        read_enable  = re;
        @(negedge clk);
    endtask

    int wp;

    initial begin
        rst = 1'b1; err_clear = 1'b0;
        write_enable = 1'b0; write_data = '0; read_enable = 1'b0;
        @(negedge clk);
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h77, 1'b1);
        rst = 1'b0;

        // Reset state
        check("rst_count", 32'(count0), 32'd0);
        check("rst_empty", 32'(empty0), 32'd1);
        check("rst_ae",    32'(ae0),    32'd1);
        check("rst_full",  32'(full0),  32'd0);
        check("rst_rv",    32'(rv0),    32'd0);
        check("rst_rd",    32'(rd0),    32'd0);

        // Fill with 0x00..0x1F
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(i), 1'b0);
            if (i == 3)  check("fill_ae_at4",  32'(ae0), 32'd1);
            if (i == 4)  check("fill_ae_at5",  32'(ae0), 32'd0);
            if (i == 26) check("fill_af_at27", 32'(af0), 32'd0);
            if (i == 27) check("fill_af_at28", 32'(af0), 32'd1);
        end
        check("fill_full",  32'(full0),  32'd1);
        check("fill_count", 32'(count0), 32'd32);
        step(1'b1, 8'hEE, 1'b0);
        check("ovr_count", 32'(count0), 32'd32);
`ifdef FIFO_MEMORY_ERR_FLAGS_EN
        check("ovr_flag", 32'(ovf0), 32'd1);
`endif

        // Drain
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1);
            check("drain_rd", 32'(rd0), 32'(i));
            check("drain_rv", 32'(rv0), 32'd1);
        end
        check("drain_empty", 32'(empty0), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        check("udr_rd", 32'(rd0), 32'h1F);
        check("udr_rv", 32'(rv0), 32'd0);
`ifdef FIFO_MEMORY_ERR_FLAGS_EN
        check("udr_flag", 32'(unf0), 32'd1);
        err_clear = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        err_clear = 1'b0;
        check("clr_ovf", 32'(ovf0), 32'd0);
        check("clr_unf", 32'(unf0), 32'd0);
`endif

        // Wrap-around
        for (int i = 0; i < 20; i++) step(1'b1, 8'(i + 8'h20), 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 8'(i + 8'h40), 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 8'h00, 1'b1);
            check("wrap_rd", 32'(rd0), 32'(i + 8'h40));
        end
        check("wrap_count", 32'(count0), 32'd0);

        // Simultaneous read+write
        for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom_range(255)), 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'($urandom_range(255)), 1'b1);
            check("simul_count16", 32'(count0), 32'd16);
        end
        for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom_range(255)), 1'b0);
        check("simul_full", 32'(full0), 32'd1);
        step(1'b1, 8'h99, 1'b1);
        check("simul_full_rw", 32'(count0), 32'd31);
        for (int i = 0; i < 31; i++) step(1'b0, 8'h00, 1'b1);
        check("simul_empty", 32'(empty0), 32'd1);
        step(1'b1, 8'h5A, 1'b1);
        check("simul_empty_rw", 32'(count0), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        check("simul_rd5a", 32'(rd0), 32'h5A);

        // FWFT visibility
        step(1'b1, 8'hA5, 1'b0);
        check("fwft_empty", 32'(empty1), 32'd0);
        check("fwft_rv",    32'(rv1),    32'd1);
        check("fwft_rd",    32'(rd1),    32'hA5);
        step(1'b0, 8'h00, 1'b1);
        check("fwft_pop_empty", 32'(empty1), 32'd1);

        // Reset mid-operation
        for (int i = 0; i < 10; i++) step(1'b1, 8'(i), 1'b0);
        check("mid_count10", 32'(count0), 32'd10);
        rst = 1'b1;
        step(1'b1, 8'hFF, 1'b0);
        rst = 1'b0;
        check("mid_count", 32'(count0), 32'd0);
        check("mid_empty", 32'(empty0), 32'd1);
        check("mid_ae",    32'(ae0),    32'd1);
`ifdef FIFO_MEMORY_ERR_FLAGS_EN
        check("mid_ovf", 32'(ovf0), 32'd0);
        check("mid_unf", 32'(unf0), 32'd0);
`endif
        step(1'b1, 8'h3C, 1'b0);
        check("mid_fwft_rd", 32'(rd1), 32'h3C);
        step(1'b0, 8'h00, 1'b1);
        check("mid_rd", 32'(rd0), 32'h3C);
        check("mid_rv", 32'(rv0), 32'd1);

        // Randomised traffic with shifting bias to visit full and empty repeatedly
        for (int blk = 0; blk < 12; blk++) begin
            wp = $urandom_range(90, 10);
            for (int c = 0; c < 200; c++) begin
                err_clear = ($urandom_range(15) == 0);
                rst       = ($urandom_range(299) == 0);
                step($urandom_range(99) < wp, 8'($urandom_range(255)),
                     $urandom_range(99) < (100 - wp));
            end
        end
        rst = 1'b0; err_clear = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
